// File: rtl/pwm_period_gen_pkg.sv
// Shared definitions for the PWM period generator: FSM encoding, default
// timing parameters and a counter-width helper.
package pwm_period_gen_pkg;

    localparam int unsigned DEF_SYS_CLK_HZ = 125_000_000;
    localparam int unsigned DEF_STEPS      = 1000;
    localparam int unsigned DEF_DUTY_W     = 10;
    localparam int unsigned DEF_FREQ_W     = 8;
    localparam int unsigned DEF_DIV_W      = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_period_gen_seq_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// done pulses DIV_W+1 clocks after an accepted start; start is ignored while busy.
module pwm_period_gen_seq_divider
    import pwm_period_gen_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] r_rem;
    logic [DIV_W-1:0] r_quo;
    logic [DIV_W-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_running;
    logic             r_done;

    logic [DIV_W:0]   w_rem_shift;
    logic [DIV_W-1:0] w_rem_sub;
    logic             w_fits;

    // The partial remainder is always below the divisor, so DIV_W bits hold
    // it; only the shifted trial value needs the extra top bit.
    always_comb begin
        w_rem_shift = {r_rem, r_quo[DIV_W-1]};
        w_fits      = (w_rem_shift >= {1'b0, r_dvs});
        w_rem_sub   = w_rem_shift[DIV_W-1:0] - r_dvs;
    end

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_running) begin
                r_rem     <= '0;
                r_quo     <= dividend;
                r_dvs     <= divisor;
                r_cnt     <= CNT_W'(DIV_W);
                r_running <= 1'b1;
            end else if (r_running) begin
                r_rem <= w_fits ? w_rem_sub : w_rem_shift[DIV_W-1:0];
                r_quo <= {r_quo[DIV_W-2:0], w_fits};
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_running <= 1'b0;
                    r_done    <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_quo;
    assign done     = r_done;

endmodule

// File: rtl/pwm_period_gen.sv
// PWM generator with a run-time computed step prescaler. Duty is shadowed and
// only taken at period boundaries so pulses are never truncated or stretched.
module pwm_period_gen
    import pwm_period_gen_pkg::*;
#(
    parameter int unsigned SYS_CLK_HZ = DEF_SYS_CLK_HZ,
    parameter int unsigned STEPS      = DEF_STEPS,
    parameter int unsigned DUTY_W     = DEF_DUTY_W,
    parameter int unsigned FREQ_W     = DEF_FREQ_W,
    parameter int unsigned DIV_W      = DEF_DIV_W
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic [DUTY_W-1:0] duty,
    input  logic [FREQ_W-1:0] pwm_freq,
    output logic              pwm_out,
    output logic              period_start,
    output logic              busy,
    output logic [DUTY_W-1:0] duty_active
);

    localparam int unsigned STEP_W = cnt_width(STEPS);
    localparam int unsigned CMP_W  = (STEP_W > DUTY_W) ? STEP_W : DUTY_W;

    logic [1:0]        r_state;
    logic [FREQ_W-1:0] r_freq_q;
    logic [DIV_W-1:0]  r_div_q;
    logic [DIV_W-1:0]  r_pre_cnt;
    logic [STEP_W-1:0] r_step_cnt;
    logic [DUTY_W-1:0] r_duty_active;
    logic              r_pwm;
    logic              r_period_start;
    logic              r_busy;

    logic              w_freq_on;
    logic              w_freq_chg;
    logic              w_div_start;
    logic [DIV_W-1:0]  w_divisor;
    logic [DIV_W-1:0]  w_dividend;
    logic [DIV_W-1:0]  w_quotient;
    logic [DIV_W-1:0]  w_quo_clamped;
    logic              w_div_done;
    logic              w_boundary;
    logic              w_pre_wrap;
    logic [DUTY_W-1:0] w_duty_sat;
    logic [DUTY_W-1:0] w_duty_eff;

    // The divider latches its operands on start, so it is fed straight from
    // pwm_freq on the same clock that freq_q captures it.
    assign w_freq_on   = (pwm_freq != '0);
    assign w_freq_chg  = (pwm_freq != r_freq_q);
    assign w_div_start = w_freq_on && ((r_state == ST_IDLE) ||
                                       (r_state == ST_RUN && w_freq_chg));
    assign w_divisor   = DIV_W'(pwm_freq) * DIV_W'(STEPS);
    assign w_dividend  = DIV_W'(SYS_CLK_HZ);

    pwm_period_gen_seq_divider #(
        .DIV_W    (DIV_W)
    ) u_div (
        .clk      (clk),
        .reset_p  (reset_p),
        .start    (w_div_start),
        .dividend (w_dividend),
        .divisor  (w_divisor),
        .quotient (w_quotient),
        .done     (w_div_done)
    );

    // NOTE: every signal driven here has a full assignment on all paths, so
    // no latch can be inferred from this combinational block.
    always_comb begin
        w_quo_clamped = (w_quotient == '0) ? DIV_W'(1) : w_quotient;
        w_boundary    = (r_step_cnt == '0) && (r_pre_cnt == '0);
        w_pre_wrap    = (r_pre_cnt == r_div_q - DIV_W'(1));
        w_duty_sat    = (duty > DUTY_W'(STEPS)) ? DUTY_W'(STEPS) : duty;
        w_duty_eff    = w_boundary ? w_duty_sat : r_duty_active;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state        <= ST_IDLE;
            r_freq_q       <= '0;
            r_div_q        <= DIV_W'(1);
            r_pre_cnt      <= '0;
            r_step_cnt     <= '0;
            r_duty_active  <= '0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_period_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_pwm <= 1'b0;
                    if (w_freq_on) begin
                        r_freq_q <= pwm_freq;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_pwm <= 1'b0;
                    if (w_div_done) begin
                        r_div_q    <= w_quo_clamped;
                        r_pre_cnt  <= '0;
                        r_step_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A frequency change abandons the period, even on a boundary clock.
                    if (w_freq_chg) begin
                        r_freq_q <= pwm_freq;
                        r_pwm    <= 1'b0;
                        if (w_freq_on) begin
                            r_busy  <= 1'b1;
                            r_state <= ST_CALC;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        if (w_boundary) begin
                            r_duty_active  <= w_duty_sat;
                            r_period_start <= 1'b1;
                        end
                        r_pwm <= (CMP_W'(r_step_cnt) < CMP_W'(w_duty_eff));
                        if (w_pre_wrap) begin
                            r_pre_cnt  <= '0;
                            r_step_cnt <= (r_step_cnt == STEP_W'(STEPS - 1)) ?
                                          '0 : r_step_cnt + STEP_W'(1);
                        end else begin
                            r_pre_cnt <= r_pre_cnt + DIV_W'(1);
                        end
                    end
                end
                default: begin
                    r_pwm   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
    assign busy         = r_busy;
    assign duty_active  = r_duty_active;

endmodule

// File: tb/tb_pwm_period_gen.sv
// Scoreboard bench: stimulus queues expected busy pulses and completed periods,
// a negedge monitor measures them from the DUT outputs and compares.
module tb_pwm_period_gen;

    localparam int SYS_CLK_HZ = 100_000;
    localparam int STEPS      = 1000;
    localparam int DUTY_W     = 10;
    localparam int FREQ_W     = 8;
    localparam int DIV_W      = 32;

    typedef enum int {EV_BUSY = 0, EV_PERIOD = 1} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       duty;
        int       high;
        int       len;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset_p;
    logic [DUTY_W-1:0] duty;
    logic [FREQ_W-1:0] pwm_freq;
    logic              pwm_out;
    logic              period_start;
    logic              busy;
    logic [DUTY_W-1:0] duty_active;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clk = ~clk;

    pwm_period_gen #(
        .SYS_CLK_HZ   (SYS_CLK_HZ),
        .STEPS        (STEPS),
        .DUTY_W       (DUTY_W),
        .FREQ_W       (FREQ_W),
        .DIV_W        (DIV_W)
    ) dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .duty         (duty),
        .pwm_freq     (pwm_freq),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .busy         (busy),
        .duty_active  (duty_active)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic push_busy(input int len);
        ev_t e;
        e.kind = EV_BUSY; e.duty = 0; e.high = 0; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic push_period(input int d, input int h, input int l);
        ev_t e;
        e.kind = EV_PERIOD; e.duty = d; e.high = h; e.len = l;
        exp_q.push_back(e);
    endtask

    task automatic score(input ev_t got);
        ev_t e;
        check("scoreboard_entry_available", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("event_kind", int'(got.kind), int'(e.kind));
        if (e.kind == EV_BUSY) begin
            check("busy_len", got.len, e.len);
        end else begin
            check("period_duty_active", got.duty, e.duty);
            check("period_high_clks", got.high, e.high);
            check("period_len_clks", got.len, e.len);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        int  in_period = 0;
        int  busy_len  = 0;
        ev_t cur;
        cur.kind = EV_PERIOD; cur.duty = 0; cur.high = 0; cur.len = 0;
        forever begin
            @(negedge clk);
            if (reset_p) begin
                in_period = 0;
                busy_len  = 0;
            end else begin
                if (busy) begin
                    busy_len++;
                    in_period = 0;
                end else if (busy_len > 0) begin
                    ev_t b;
                    b.kind = EV_BUSY; b.duty = 0; b.high = 0; b.len = busy_len;
                    score(b);
                    busy_len = 0;
                end
                if (period_start) begin
                    if (in_period != 0) score(cur);
                    in_period = 1;
                    cur.duty  = int'(duty_active);
                    cur.high  = 0;
                    cur.len   = 0;
                end
                if (in_period != 0) begin
                    cur.len++;
                    if (pwm_out) cur.high++;
                end
            end
        end
    end

    task automatic wait_ps(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (period_start) return;
        end
        n_checks++;
        $display("FAIL period_start_wait: none within %0d clks, required one (t=%0t)", budget, $time);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

    initial begin
        reset_p  = 1'b1;
        duty     = '0;
        pwm_freq = '0;
        cycles(3);
        check("reset_pwm_out", pwm_out, 0);
        check("reset_period_start", period_start, 0);
        check("reset_busy", busy, 0);
        check("reset_duty_active", duty_active, 0);
        reset_p = 1'b0;
        cycles(5);
        check("idle_busy", busy, 0);
        check("idle_pwm_out", pwm_out, 0);

        // freq 50 Hz, duty 77: divisor 2, 154 high clks per 2000
        push_busy(33);
        push_period(77, 154, 2000);
        push_period(77, 154, 2000);
        duty     = 10'd77;
        pwm_freq = 8'd50;
        wait_ps(100);
        wait_ps(2100);
        wait_ps(2100);

        // duty change inside the high phase takes effect next period
        push_period(77, 154, 2000);
        push_period(128, 256, 2000);
        cycles(100);
        duty = 10'd128;
        check("duty_held_mid_period", duty_active, 77);
        wait_ps(2100);
        check("duty_applied_at_boundary", duty_active, 128);
        wait_ps(2100);

        // constant low, constant high, saturation of out-of-range duty
        push_period(128, 256, 2000);
        push_period(0, 0, 2000);
        push_period(1000, 2000, 2000);
        push_period(1000, 2000, 2000);
        duty = 10'd0;
        wait_ps(2100);
        duty = 10'd1000;
        wait_ps(2100);
        duty = 10'd1023;
        wait_ps(2100);
        wait_ps(2100);
        check("duty_saturated", duty_active, 1000);

        // frequency change mid-period: period abandoned, recompute, div 1
        cycles(500);
        check("pwm_high_before_freq_change", pwm_out, 1);
        push_busy(33);
        push_period(300, 300, 1000);
        push_period(300, 300, 1000);
        duty     = 10'd300;
        pwm_freq = 8'd100;
        cycles(1);
        check("freq_change_pwm_low", pwm_out, 0);
        check("freq_change_busy", busy, 1);
        wait_ps(100);
        wait_ps(1100);
        wait_ps(1100);

        // frequency to zero: back to idle, output stays low, no periods
        cycles(200);
        check("pwm_high_before_off", pwm_out, 1);
        pwm_freq = 8'd0;
        cycles(1);
        check("off_pwm_low", pwm_out, 0);
        check("off_busy", busy, 0);
        cycles(300);
        check("off_pwm_still_low", pwm_out, 0);

        // quotient 0 clamps to 1
        push_busy(33);
        push_period(500, 500, 1000);
        push_period(500, 500, 1000);
        duty     = 10'd500;
        pwm_freq = 8'd200;
        wait_ps(100);
        wait_ps(1100);
        wait_ps(1100);

        // asynchronous reset inside the high phase
        cycles(10);
        #2;
        check("pwm_high_before_reset", pwm_out, 1);
        reset_p = 1'b1;
        #1;
        check("async_reset_pwm_out", pwm_out, 0);
        check("async_reset_period_start", period_start, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_duty_active", duty_active, 0);
        cycles(2);
        push_busy(33);
        push_period(500, 500, 1000);
        reset_p = 1'b0;
        wait_ps(100);
        wait_ps(1100);

        cycles(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
